feedback_scorer: RTL and testbench
==================================

// Module: feedback_scorer
// PURPOSE
//  Downstream of the guess-history stage. On each committed guess, scores the
//  4-symbol guess against the secret code: exact = right symbol in the right
//  position; partial = right symbol in the wrong position, each secret symbol
//  used at most once.
//  Sequential scan with a fixed latency. Drives the peg display and win/lose.
// PARAMETERS
//  DIGIT_W  3  width of one code symbol (symbols 0..2^DIGIT_W-1)
// PORTS
//  clk        in   1        system clock, all state on posedge
//  reset      in   1        ASYNCHRONOUS, ACTIVE-LOW reset (0 = reset)
//  start      in   1        1-cycle pulse: score current guess (ignored unless IDLE)
//  guess3..0  in   DIGIT_W  guess symbols, position 3..0; sampled on accepted start
//  secret3..0 in   DIGIT_W  secret symbols; sampled on accepted start
//  last_turn  in   1        guess being scored is the final turn; sampled on start
//  busy       out  1        1 from the cycle after start accepted until done
//  done       out  1        1-cycle pulse: exact/partial valid and updated
//  exact      out  3        exact-match count, 0..4
//  partial    out  3        partial-match count, 0..4; exact+partial <= 4
//  win        out  1        sticky: some scored guess had exact==4
//  lose       out  1        sticky: last_turn guess scored with exact!=4
// BEHAVIOUR
//  - Reset (reset==0, any time, incl. mid-scan): state=IDLE.
//    busy=done=win=lose=0, exact=partial=0.
//    Internal used/matched flags are cleared. No partial result is ever emitted.
//  - FSM: IDLE -> EXACT -> PARTIAL -> DONE -> IDLE.
//  - IDLE: start==1 && !win && !lose at edge E:
//    * latch guess/secret/last_turn; exact=partial=0
//    * clear g_match[3:0] and s_used[3:0]; go to EXACT
//    Otherwise start is ignored.
//  - EXACT: 4 cycles (edges E+1..E+4), position p=0..3, one per cycle.
//    If g[p]==s[p]: exact++, g_match[p]=1, s_used[p]=1.
//  - PARTIAL: 16 cycles (edges E+5..E+20); i=0..3 outer, j=0..3 inner.
//    If !g_match[i] && !s_used[j] && g[i]==s[j]: partial++, g_match[i]=1,
//    s_used[j]=1.
//    Always walks all 16 pairs, so latency is data-independent.
//  - DONE: entered at edge E+21, done=1 for exactly one cycle, busy drops.
//    Also at E+21: win<=1 if exact==4; else lose<=1 if latched last_turn==1.
//    Edge E+22: back to IDLE, done=0.
//  - busy=1 during EXACT and PARTIAL only (edges E+1..E+20 outputs).
//  - exact/partial count up during the scan; they are final when done=1.
//    They hold until the next accepted start or reset.
//  - start while busy or in DONE: ignored, not queued.
//  - Input changes after start is accepted: no effect (latched copies used).
//  - After win or lose: all starts ignored until reset (game over).
//  - Counters are 3 bits and can never exceed 4; no wrap.
//  - Symbol compare is full DIGIT_W-bit equality; symbol 0 is an ordinary
//    value.
// TESTING
//  1. secret{3..0}={1,2,3,4}, guess={1,2,3,4}, start at E -> done at E+21,
//     exact=4, partial=0, win=1, busy low at done.
//  2. secret={1,2,3,4}, guess={4,3,2,1} -> exact=0, partial=4, win=0, lose=0.
//  3. Duplicates: secret={1,1,2,2}, guess={1,2,1,1} -> exact=1, partial=2.
//     Same secret, guess={0,0,0,0} -> exact=0, partial=0.
//  4. start, second start pulsed at E+5 -> only one done (at E+21).
//     reset low at E+10 -> busy=done=exact=partial=0 at once (async).
//     A fresh start after reset scores normally.
//  5. last_turn=1, secret={5,5,5,5}, guess={5,5,5,0} -> exact=3, lose=1,
//     win=0. A further start is ignored: busy stays 0, no done.

Source files
------------

// File: rtl/feedback_scorer.sv
// Mastermind-style guess scorer: walks the 4 exact positions, then all 16 guess/secret
// pairs for partial matches, so the latency is fixed. Also keeps the sticky win/lose flags.
module feedback_scorer #(
  parameter int unsigned DIGIT_W = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [DIGIT_W-1:0] guess3_i,
  input  logic [DIGIT_W-1:0] guess2_i,
  input  logic [DIGIT_W-1:0] guess1_i,
  input  logic [DIGIT_W-1:0] guess0_i,
  input  logic [DIGIT_W-1:0] secret3_i,
  input  logic [DIGIT_W-1:0] secret2_i,
  input  logic [DIGIT_W-1:0] secret1_i,
  input  logic [DIGIT_W-1:0] secret0_i,
  input  logic               last_turn_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2:0]         exact_o,
  output logic [2:0]         partial_o,
  output logic               win_o,
  output logic               lose_o
);

  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXACT,
    S_PARTIAL,
    S_DONE
  } state_e;

  state_e                    state_q;
  logic [3:0][DIGIT_W-1:0]   g_q;
  logic [3:0][DIGIT_W-1:0]   s_q;
  logic [3:0]                g_match_q;
  logic [3:0]                s_used_q;
  logic                      last_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [2:0]                exact_q;
  logic [2:0]                partial_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      win_q;
  logic                      lose_q;

  logic [1:0]                idx_i_c;
  logic [1:0]                idx_j_c;
  logic                      exact_hit_c;
  logic                      partial_hit_c;

  // Pair indices come straight from the scan counter: i in [3:2], j (or p) in [1:0].
  always_comb begin
    idx_i_c       = cnt_q[3:2];
    idx_j_c       = cnt_q[1:0];
    exact_hit_c   = (g_q[idx_j_c] == s_q[idx_j_c]);
    partial_hit_c = !g_match_q[idx_i_c] && !s_used_q[idx_j_c] &&
                    (g_q[idx_i_c] == s_q[idx_j_c]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      g_q       <= '0;
      s_q       <= '0;
      g_match_q <= '0;
      s_used_q  <= '0;
      last_q    <= 1'b0;
      cnt_q     <= '0;
      exact_q   <= 3'd0;
      partial_q <= 3'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      win_q     <= 1'b0;
      lose_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i && !win_q && !lose_q) begin
            g_q       <= {guess3_i, guess2_i, guess1_i, guess0_i};
            s_q       <= {secret3_i, secret2_i, secret1_i, secret0_i};
            last_q    <= last_turn_i;
            g_match_q <= '0;
            s_used_q  <= '0;
            exact_q   <= 3'd0;
            partial_q <= 3'd0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_EXACT;
          end
        end
        S_EXACT: begin
          if (exact_hit_c) begin
            exact_q            <= exact_q + 3'd1;
            g_match_q[idx_j_c] <= 1'b1;
            s_used_q[idx_j_c]  <= 1'b1;
          end
          if (idx_j_c == 2'd3) begin
            cnt_q   <= '0;
            state_q <= S_PARTIAL;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_PARTIAL: begin
          // cnt_q[4] set means all 16 pairs have been visited.
          if (cnt_q[4]) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
            if (exact_q == 3'd4) begin
              win_q <= 1'b1;
            end else if (last_q) begin
              lose_q <= 1'b1;
            end
          end else begin
            if (partial_hit_c) begin
              partial_q          <= partial_q + 3'd1;
              g_match_q[idx_i_c] <= 1'b1;
              s_used_q[idx_j_c]  <= 1'b1;
            end
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign exact_o   = exact_q;
  assign partial_o = partial_q;
  assign win_o     = win_q;
  assign lose_o    = lose_q;

endmodule

// File: tb/tb_feedback_scorer.sv
// Bench for feedback_scorer: a cycle-count/multiset-count reference model checked every
// cycle, plus hand-computed expectations for the directed game scenarios.
module tb_feedback_scorer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] g3, g2, g1, g0, s3, s2, s1, s0;
  logic       last_turn;
  logic       busy, done, win, lose;
  logic [2:0] exact, partial;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  feedback_scorer #(.DIGIT_W(3)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .guess3_i(g3), .guess2_i(g2), .guess1_i(g1), .guess0_i(g0),
    .secret3_i(s3), .secret2_i(s2), .secret1_i(s1), .secret0_i(s0),
    .last_turn_i(last_turn),
    .busy_o(busy), .done_o(done), .exact_o(exact), .partial_o(partial),
    .win_o(win), .lose_o(lose)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference score: exact by position, partial = sum of per-symbol min counts minus exact.
  function automatic void score(input logic [11:0] g, input logic [11:0] s,
                                output int ex, output int pa);
    int cg[8];
    int cs[8];
    int tot;
    ex = 0;
    tot = 0;
    for (int k = 0; k < 8; k++) begin cg[k] = 0; cs[k] = 0; end
    for (int p = 0; p < 4; p++) begin
      if (g[p*3 +: 3] == s[p*3 +: 3]) ex++;
      cg[g[p*3 +: 3]]++;
      cs[s[p*3 +: 3]]++;
    end
    for (int k = 0; k < 8; k++) tot += (cg[k] < cs[k]) ? cg[k] : cs[k];
    pa = tot - ex;
  endfunction

  // Model: k counts edges since the accepting edge (-1 = idle).
  int m_k = -1;
  int m_ex = 0, m_pa = 0, f_ex = 0, f_pa = 0;
  bit m_win = 0, m_lose = 0, m_last = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k <= -1; m_ex <= 0; m_pa <= 0; m_win <= 0; m_lose <= 0;
    end else if (m_k < 0) begin
      if (start && !m_win && !m_lose) begin
        int e, p;
        score({g3, g2, g1, g0}, {s3, s2, s1, s0}, e, p);
        f_ex <= e; f_pa <= p; m_last <= last_turn;
        m_ex <= 0; m_pa <= 0; m_k <= 0;
      end
    end else begin
      if (m_k + 1 == 21) begin
        m_ex <= f_ex; m_pa <= f_pa;
        if (f_ex == 4) m_win <= 1;
        else if (m_last) m_lose <= 1;
      end
      m_k <= (m_k + 1 == 22) ? -1 : m_k + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_busy", int'(busy), int'(m_k >= 0 && m_k <= 20));
      chk("m_done", int'(done), int'(m_k == 21));
      chk("m_win", int'(win), int'(m_win));
      chk("m_lose", int'(lose), int'(m_lose));
      if (!(m_k >= 0 && m_k <= 20)) begin
        chk("m_exact", int'(exact), m_ex);
        chk("m_partial", int'(partial), m_pa);
      end
      if (done) done_cnt++;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Pulse start with given code, scramble inputs afterwards, wait for done (bounded).
  task automatic run(input logic [11:0] g, input logic [11:0] s, input logic lt,
                     input int second_at, output int lat);
    @(negedge clk);
    {g3, g2, g1, g0} = g; {s3, s2, s1, s0} = s; last_turn = lt; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    {g3, g2, g1, g0, s3, s2, s1, s0} = 24'($urandom);
    last_turn = ~lt;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == second_at) start = 1'b1;
      else start = 1'b0;
    end
    start = 1'b0;
    if (!done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int lat, d0;
    rst_n = 1'b0; start = 1'b0; last_turn = 1'b0;
    {g3, g2, g1, g0, s3, s2, s1, s0} = '0;
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_exact", int'(exact), 0);
    chk("rst_partial", int'(partial), 0);
    chk("rst_win", int'(win), 0);
    chk("rst_lose", int'(lose), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reversed code: all partial.
    run({3'd4, 3'd3, 3'd2, 3'd1}, {3'd1, 3'd2, 3'd3, 3'd4}, 1'b0, -1, lat);
    chk("t2_lat", lat, 21);
    chk("t2_exact", int'(exact), 0);
    chk("t2_partial", int'(partial), 4);
    chk("t2_win", int'(win), 0);
    chk("t2_lose", int'(lose), 0);

    // Duplicates.
    run({3'd1, 3'd2, 3'd1, 3'd1}, {3'd1, 3'd1, 3'd2, 3'd2}, 1'b0, -1, lat);
    chk("t3_exact", int'(exact), 1);
    chk("t3_partial", int'(partial), 2);
    run({3'd0, 3'd0, 3'd0, 3'd0}, {3'd1, 3'd1, 3'd2, 3'd2}, 1'b0, -1, lat);
    chk("t3z_exact", int'(exact), 0);
    chk("t3z_partial", int'(partial), 0);
    @(negedge clk);
    chk("t3z_hold", int'(partial), 0);

    // Second start at E+5 is ignored: exactly one done.
    d0 = done_cnt;
    run({3'd0, 3'd7, 3'd0, 3'd6}, {3'd7, 3'd0, 3'd0, 3'd6}, 1'b0, 4, lat);
    chk("t4_lat", lat, 21);
    chk("t4_exact", int'(exact), 2);
    chk("t4_partial", int'(partial), 2);
    repeat (25) @(negedge clk);
    chk("t4_done_count", done_cnt - d0, 1);

    // Async reset mid-scan.
    @(negedge clk);
    {g3, g2, g1, g0} = {3'd2, 3'd2, 3'd2, 3'd2};
    {s3, s2, s1, s0} = {3'd2, 3'd2, 3'd2, 3'd2};
    last_turn = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t4r_busy", int'(busy), 0);
    chk("t4r_done", int'(done), 0);
    chk("t4r_exact", int'(exact), 0);
    chk("t4r_partial", int'(partial), 0);
    chk("t4r_win", int'(win), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh start after reset: win.
    run({3'd1, 3'd2, 3'd3, 3'd4}, {3'd1, 3'd2, 3'd3, 3'd4}, 1'b0, -1, lat);
    chk("t1_lat", lat, 21);
    chk("t1_exact", int'(exact), 4);
    chk("t1_partial", int'(partial), 0);
    chk("t1_busy", int'(busy), 0);
    @(negedge clk);
    chk("t1_win", int'(win), 1);
    chk("t1_lose", int'(lose), 0);

    // Final turn lost, then game over.
    do_reset();
    run({3'd5, 3'd5, 3'd5, 3'd0}, {3'd5, 3'd5, 3'd5, 3'd5}, 1'b1, -1, lat);
    chk("t5_exact", int'(exact), 3);
    chk("t5_partial", int'(partial), 0);
    @(negedge clk);
    chk("t5_lose", int'(lose), 1);
    chk("t5_win", int'(win), 0);
    d0 = done_cnt;
    @(negedge clk);
    {g3, g2, g1, g0} = {3'd5, 3'd5, 3'd5, 3'd5};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t5_ignored_busy", int'(busy), 0);
    repeat (25) @(negedge clk);
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_exact_hold", int'(exact), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
